xbus_arbiter: RTL and testbench

- Shared-XBus arbiter for the Shenzhen-I/O emulator.
- Lets NUM_PORTS MC9999-style devices share one XBus channel instead of point-to-point x0/x1 wiring.
- Each cycle it can pair one pending writer with one pending reader on a different port, using independent round-robin selection for each.
- It moves the 11-bit word from writer to reader and completes the transfer with a 4-phase request/ack handshake.

---
 rtl/xbus_pkg.sv | 13 +
 rtl/xbus_arbiter_if.sv | 23 ++
 rtl/rr_pick.sv | 29 ++
 rtl/xbus_arbiter.sv | 140 ++++++++++++++
 tb/tb_xbus_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_pkg.sv
// Shared definitions for the XBus arbiter: FSM encoding and XBus word limits.
package xbus_pkg;

    localparam int XBUS_W   = 11;
    localparam int XBUS_MAX = 999;
    localparam int XBUS_MIN = -999;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/xbus_arbiter_if.sv
// XBus request/ack bundle between NUM_PORTS devices (master side) and the arbiter (slave side).
interface xbus_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 11
);
    logic [NUM_PORTS-1:0]        wr_req;
    logic [NUM_PORTS*DATA_W-1:0] wr_data;
    logic [NUM_PORTS-1:0]        rd_req;
    logic [NUM_PORTS-1:0]        wr_ack;
    logic [NUM_PORTS-1:0]        rd_ack;
    logic [DATA_W-1:0]           rd_data;
    logic                        busy;

    modport master (
        output wr_req, wr_data, rd_req,
        input  wr_ack, rd_ack, rd_data, busy
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output wr_ack, rd_ack, rd_data, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin finder: first set request at or after start (mod N), optionally skipping one index.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic [PW-1:0] excl,
    input  logic          excl_en,
    output logic          found,
    output logic [PW-1:0] idx
);

    // Scan farthest-first so the nearest hit to start is the last one written.
    always_comb begin : scan
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (req[j] && !(excl_en && (j == int'(excl)))) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus arbiter: pairs one writer with one reader on another port and holds a 4-phase ack.
// Optional statistics counters are built when XBUS_ARB_STATS_EN is defined.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = XBUS_W
) (
    input  logic        clk,
    input  logic        rst_n,
    xbus_arbiter_if.slave bus
`ifdef XBUS_ARB_STATS_EN
    ,
    output logic [15:0] xfer_count,
    output logic [15:0] stall_count
`endif
);

    localparam int PW = $clog2(NUM_PORTS);

    state_t               state, state_nx;
    logic [PW-1:0]        wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic [PW-1:0]        wr_sel, wr_sel_nx, rd_sel, rd_sel_nx;
    logic [NUM_PORTS-1:0] wr_ack_q, wr_ack_nx, rd_ack_q, rd_ack_nx;
    logic [DATA_W-1:0]    data_q, data_nx;
    logic                 busy_q, busy_nx;

    logic [NUM_PORTS-1:0] wr_elig;
    logic [DATA_W-1:0]    words [NUM_PORTS];
    logic                 wr_found, rd_found, pair;
    logic [PW-1:0]        wr_idx, rd_idx;

    // A writer is only eligible if some other port is reading; this gives the writer fallback.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign wr_elig[i] = bus.wr_req[i] & |(bus.rd_req & ~(NUM_PORTS'(1) << i));
        assign words[i]   = bus.wr_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(NUM_PORTS), .PW(PW)) u_wr_pick (
        .req     (wr_elig),
        .start   (wr_ptr),
        .excl    ('0),
        .excl_en (1'b0),
        .found   (wr_found),
        .idx     (wr_idx)
    );

    rr_pick #(.N(NUM_PORTS), .PW(PW)) u_rd_pick (
        .req     (bus.rd_req),
        .start   (rd_ptr),
        .excl    (wr_idx),
        .excl_en (1'b1),
        .found   (rd_found),
        .idx     (rd_idx)
    );

    assign pair = wr_found & rd_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_sel   <= '0;
            rd_sel   <= '0;
            wr_ack_q <= '0;
            rd_ack_q <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            wr_sel   <= wr_sel_nx;
            rd_sel   <= rd_sel_nx;
            wr_ack_q <= wr_ack_nx;
            rd_ack_q <= rd_ack_nx;
            data_q   <= data_nx;
            busy_q   <= busy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        wr_sel_nx = wr_sel;
        rd_sel_nx = rd_sel;
        wr_ack_nx = wr_ack_q;
        rd_ack_nx = rd_ack_q;
        data_nx   = data_q;
        busy_nx   = busy_q;
        case (state)
            ST_IDLE: begin
                if (pair) begin
                    data_nx   = words[wr_idx];
                    wr_ack_nx = NUM_PORTS'(1) << wr_idx;
                    rd_ack_nx = NUM_PORTS'(1) << rd_idx;
                    busy_nx   = 1'b1;
                    wr_sel_nx = wr_idx;
                    rd_sel_nx = rd_idx;
                    wr_ptr_nx = (wr_idx == PW'(NUM_PORTS - 1)) ? '0 : wr_idx + 1'b1;
                    rd_ptr_nx = (rd_idx == PW'(NUM_PORTS - 1)) ? '0 : rd_idx + 1'b1;
                    state_nx  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.wr_req[wr_sel] && !bus.rd_req[rd_sel]) begin
                    wr_ack_nx = '0;
                    rd_ack_nx = '0;
                    busy_nx   = 1'b0;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.wr_ack  = wr_ack_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = data_q;
    assign bus.busy    = busy_q;

`ifdef XBUS_ARB_STATS_EN
    // Transfer count wraps; stall count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else if (state == ST_IDLE) begin
            if (pair) begin
                xfer_count <= xfer_count + 16'd1;
            end else if (|bus.wr_req && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed and random checks of xbus_arbiter against a rule-level pairing model.
module tb_xbus_arbiter;
    import xbus_pkg::*;

    localparam int N = 4;
    localparam int W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    xbus_arbiter_if #(.NUM_PORTS(N), .DATA_W(W)) bus ();

`ifdef XBUS_ARB_STATS_EN
    logic [15:0] xfer_count, stall_count;
    int m_xfer, m_stall;
`endif

    xbus_arbiter #(.NUM_PORTS(N), .DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef XBUS_ARB_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Model state: one transfer in flight, identified by writer/reader port.
    bit         m_busy;
    int         m_w, m_r, m_wptr, m_rptr;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_w = 0; m_r = 0; m_wptr = 0; m_rptr = 0; m_data = '0;
`ifdef XBUS_ARB_STATS_EN
        m_xfer = 0; m_stall = 0;
`endif
    endtask

    // Spec rules: try writers in RR order; for each, first other reader in RR order.
    task automatic model_edge();
        bit found;
        found = 0;
        if (!m_busy) begin
            for (int k = 0; k < N && !found; k++) begin
                int w;
                w = (m_wptr + k) % N;
                if (bus.wr_req[w]) begin
                    for (int k2 = 0; k2 < N && !found; k2++) begin
                        int r;
                        r = (m_rptr + k2) % N;
                        if (r != w && bus.rd_req[r]) begin
                            found  = 1;
                            m_w    = w;
                            m_r    = r;
                            m_data = bus.wr_data[w*W +: W];
                        end
                    end
                end
            end
            if (found) begin
                m_busy = 1;
                m_wptr = (m_w + 1) % N;
                m_rptr = (m_r + 1) % N;
            end
`ifdef XBUS_ARB_STATS_EN
            if (found) m_xfer = (m_xfer + 1) % 65536;
            else if (|bus.wr_req && m_stall < 65535) m_stall++;
`endif
        end else if (!bus.wr_req[m_w] && !bus.rd_req[m_r]) begin
            m_busy = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] ew, er;
        ew = m_busy ? (N'(1) << m_w) : '0;
        er = m_busy ? (N'(1) << m_r) : '0;
        chk({tag, ".wr_ack"}, 32'(bus.wr_ack), 32'(ew));
        chk({tag, ".rd_ack"}, 32'(bus.rd_ack), 32'(er));
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_data));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
`ifdef XBUS_ARB_STATS_EN
        chk({tag, ".xfer_count"}, 32'(xfer_count), 32'(m_xfer));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_word(input int p, input logic [W-1:0] v);
        bus.wr_data[p*W +: W] = v;
    endtask

    task automatic idle_bus();
        bus.wr_req = '0;
        bus.rd_req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_bus();
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_w[4] = '{1, 2, 3, 1};
    int exp_d[4] = '{2, 3, 4, 2};
    int exp_r[4] = '{1, 2, 3, 1};

    initial begin
        bus.wr_data = '0;
        idle_bus();
        do_reset();

        // Basic transfer
        set_word(0, 11'd42);
        bus.wr_req = 4'b0001; bus.rd_req = 4'b0100;
        step("basic_grant");
        chk("basic.wr_ack", 32'(bus.wr_ack), 32'h1);
        chk("basic.rd_ack", 32'(bus.rd_ack), 32'h4);
        chk("basic.rd_data", 32'(bus.rd_data), 32'd42);
        idle_bus();
        step("basic_release");
        chk("basic.ack_drop", 32'({bus.wr_ack, bus.rd_ack, bus.busy}), 32'h0);
        chk("basic.data_kept", 32'(bus.rd_data), 32'd42);
        step("basic_idle");

        // Self-exclusion
        do_reset();
        set_word(1, 11'(-7));
        bus.wr_req = 4'b0010; bus.rd_req = 4'b0010;
        step("self_a");
        step("self_b");
        chk("self.no_grant", 32'(bus.busy), 32'h0);
        bus.rd_req = 4'b1010;
        step("self_grant");
        chk("self.rd_ack", 32'(bus.rd_ack), 32'h8);
        chk("self.rd_data", 32'(bus.rd_data), 32'h7F9);
        idle_bus();
        step("self_release");

        // Writer fairness
        do_reset();
        for (int p = 0; p < N; p++) set_word(p, 11'(p + 1));
        for (int t = 0; t < 4; t++) begin
            bus.wr_req = 4'b1111; bus.rd_req = 4'b0001;
            step("wfair_grant");
            chk("wfair.writer", 32'(bus.wr_ack), 32'(1 << exp_w[t]));
            chk("wfair.word", 32'(bus.rd_data), 32'(exp_d[t]));
            idle_bus();
            step("wfair_release");
        end

        // Reader fairness
        do_reset();
        set_word(0, 11'd5);
        for (int t = 0; t < 4; t++) begin
            bus.wr_req = 4'b0001; bus.rd_req = 4'b1110;
            step("rfair_grant");
            chk("rfair.reader", 32'(bus.rd_ack), 32'(1 << exp_r[t]));
            idle_bus();
            step("rfair_release");
        end

        // Hold: reader keeps request, new writer arrives during ACK
        do_reset();
        set_word(0, 11'd42);
        set_word(2, 11'd99);
        bus.wr_req = 4'b0001; bus.rd_req = 4'b0010;
        step("hold_grant");
        bus.wr_req = 4'b0100; bus.rd_req = 4'b1010;
        for (int t = 0; t < 5; t++) begin
            step("hold_cycle");
            chk("hold.wr_ack", 32'(bus.wr_ack), 32'h1);
            chk("hold.rd_data", 32'(bus.rd_data), 32'd42);
        end
        bus.rd_req = 4'b1000;
        step("hold_release");
        chk("hold.released", 32'(bus.busy), 32'h0);
        step("hold_next");
        chk("hold.next_wr", 32'(bus.wr_ack), 32'h4);
        chk("hold.next_rd", 32'(bus.rd_ack), 32'h8);
        chk("hold.next_data", 32'(bus.rd_data), 32'd99);
        idle_bus();
        step("hold_done");

        // Reset mid-ACK
        set_word(0, 11'd42);
        bus.wr_req = 4'b0001; bus.rd_req = 4'b0100;
        step("rst_grant");
        bus.wr_req = 4'b1111; bus.rd_req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.async_outputs", 32'({bus.wr_ack, bus.rd_ack, bus.busy}), 32'h0);
        chk("rst.rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_first");
        chk("rst.first_wr", 32'(bus.wr_ack), 32'h1);
        chk("rst.first_rd", 32'(bus.rd_ack), 32'h2);
        idle_bus();
        step("rst_release");

        // Random traffic
        do_reset();
        for (int t = 0; t < 400; t++) begin
            bus.wr_req  = N'($urandom);
            bus.rd_req  = N'($urandom);
            bus.wr_data = (N*W)'({$urandom, $urandom});
            step("random");
            chk("random.onehot", 32'($countones(bus.wr_ack) <= 1 && $countones(bus.rd_ack) <= 1), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
